sram_bank_ctrl: RTL
===================

Name: sram_bank_ctrl

Overview:
Parametrised, byte-addressable, single-port SRAM bank with a valid/ready request interface and a registered read response. It supports per-byte write strobes and unaligned accesses: an unaligned access is split into two word beats, and byte addresses wrap around at the top of the address space. It serves as the next-generation data/instruction memory behind the core's load/store unit.

Parameters:
ADDR_W, 16, byte-address width; total capacity is 2^ADDR_W bytes.
DATA_W, 32, word width in bits; must be a multiple of 8 and a power-of-two number of bytes.
NB (localparam), DATA_W/8, bytes per word. WORDS = 2^ADDR_W/NB. OFS_W = log2(NB).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address of lane 0
req_be  in  NB  write byte enables; lane i targets byte (req_addr+i) mod 2^ADDR_W; ignored for reads
req_wdata  in  DATA_W  write data; lane i = bits [8i+7:8i]
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  DATA_W  read data; lane i = byte at (addr+i) mod 2^ADDR_W
busy  out  1  FSM not in IDLE

Behaviour:
- Storage: WORDS x DATA_W array with per-byte write mask. The array has no reset.
- Address split: word index W0 = addr >> OFS_W, offset o = addr[OFS_W-1:0], W1 = (W0+1) mod WORDS. Word WORDS-1 wraps to word 0.
- Aligned access (o == 0): one beat on W0; lane i maps to byte i.
- Unaligned access (o != 0):
  - Beat 0 on W0: lanes 0..NB-1-o map to bytes o..NB-1.
  - Beat 1 on W1: lanes NB-o..NB-1 map to bytes 0..o-1.
  - Both beats always execute, even when all enables in a beat are 0.
- FSM states:
  - IDLE: req_ready = 1.
    - Accepted aligned write: commit at that edge, stay IDLE.
    - Accepted unaligned write: commit beat 0, latch addr/be/data, go to SPLIT.
    - Accepted aligned read: register the word, go to RESP.
    - Accepted unaligned read: capture beat 0, go to SPLIT.
  - SPLIT: req_ready = 0. Execute beat 1 (write, or read and merge). Write goes to IDLE; read goes to RESP.
  - RESP: rsp_valid = 1. req_ready = rsp_ready (combinational path is permitted).
    - rsp_ready && !req_valid: go to IDLE.
    - rsp_ready && req_valid: accept the new request this cycle, with the same transitions as from IDLE.
- Latency, counted in edges from the accept edge T:
  - Aligned read: rsp_valid high after edge T.
  - Unaligned read: rsp_valid high after edge T+1.
  - Aligned write: memory updated at T.
  - Unaligned write: both beats complete at T+1.
- Writes produce no response.
- While rsp_valid && !rsp_ready, rsp_rdata and rsp_valid hold stable.
- rsp_rdata updates only when a new read response loads.
- Reset values: rsp_valid = 0, rsp_rdata = 0, FSM = IDLE (or INIT, see Optional Feature), busy = 0, req_ready = 1 once rst_n is high.
- Reset asserted mid-operation:
  - FSM is forced to its reset state immediately; any pending response is dropped.
  - An unaligned write interrupted after beat 0 keeps beat 0 committed.
- Unaligned throughput: 1 request per 2 cycles. Aligned writes: 1 per cycle. Aligned reads: 1 per cycle when rsp_ready is held high.

Optional Feature:
SRAM_INIT_CLEAR_EN:
- Defined:
  - Reset state is INIT.
  - After rst_n rises, an internal counter writes zero to words 0..WORDS-1, one word per cycle.
  - During INIT: req_ready = 0, busy = 1.
  - After the last word, go to IDLE. INIT lasts WORDS cycles.
  - A reset during INIT restarts the clear from word 0.
- Undefined: no INIT state, and memory contents are undefined after reset.

Test Plan:
1. Write 0x0010, be 1111, 0xDEADBEEF; then read 0x0010 -> rsp_valid one edge after accept, rdata 0xDEADBEEF.
2. Write 0x0010, be 0101, 0x11223344; read 0x0010 -> 0xDE22BE44.
3. Write 0x0014, be 1111, 0xCAFEF00D; read 0x0012 -> rsp_valid two edges after accept, rdata 0xF00DDE22; busy high during SPLIT.
4. Write 0xFFFE, be 1111, 0xA1B2C3D4 -> bytes FFFE=D4, FFFF=C3, 0000=B2, 0001=A1. Read 0x0000 -> rdata[15:0] = 0xA1B2. Read 0xFFFC -> rdata[31:16] = 0xC3D4.
5. Hold rsp_ready low 3 cycles after a read -> rsp_valid and rdata stable, req_ready 0. Then raise rsp_ready with a pending read of 0x0014 -> accepted the same cycle, next rdata 0xCAFEF00D.
6. Assert rst_n low during SPLIT of an unaligned read -> rsp_valid 0 immediately; no response after release. With SRAM_INIT_CLEAR_EN: req_ready low for 16384 cycles (default parameters), then a read of any address returns 0.

Source files
------------

// File: rtl/sram_bank_ctrl_if.sv
// Request/response bundle for sram_bank_ctrl: valid/ready request channel,
// registered read-response channel, and the busy status flag.
interface sram_bank_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [NB-1:0]     req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/sram_bank_ctrl.sv
// Byte-addressable single-port SRAM bank; unaligned accesses split into two word beats, addresses wrap.
// Latency: aligned read 1 edge, unaligned read 2 edges; aligned write commits at accept, unaligned at accept+1.
// Backpressure: req_ready low in SPLIT/INIT and follows rsp_ready while a response waits. Option: SRAM_INIT_CLEAR_EN.
module sram_bank_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_bank_ctrl_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int WI_W  = ADDR_W - OFS_W;
    localparam int WORDS = 1 << WI_W;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SPLIT = 2'd1, S_RESP = 2'd2, S_INIT = 2'd3} state_t;

`ifdef SRAM_INIT_CLEAR_EN
    localparam state_t RST_ST = S_INIT;
    logic [WI_W-1:0] r_init_cnt;
`else
    localparam state_t RST_ST = S_IDLE;
`endif

    logic [DATA_W-1:0] r_mem [WORDS];
    state_t            r_state, w_next;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [NB-1:0]     r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_part;
    logic [DATA_W-1:0] r_rdata;

    logic              w_acc, w_beat1, w_unal, w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [OFS_W-1:0]  w_ofs;
    logic [WI_W-1:0]   w_widx;
    logic [DATA_W-1:0] w_rword, w_rot;
    logic [NB-1:0]     w_lo;
    logic              w_mem_we;
    logic [WI_W-1:0]   w_mem_idx;
    logic [NB-1:0]     w_mem_mask;
    logic [DATA_W-1:0] w_mem_wdat;

    // In SPLIT the latched request drives the datapath; otherwise the live request does.
    assign w_acc   = bus.req_valid && bus.req_ready;
    assign w_beat1 = (r_state == S_SPLIT);
    assign w_addr  = w_beat1 ? r_addr  : bus.req_addr;
    assign w_be    = w_beat1 ? r_be    : bus.req_be;
    assign w_wdata = w_beat1 ? r_wdata : bus.req_wdata;
    assign w_we    = w_beat1 ? r_we    : bus.req_we;
    assign w_ofs   = w_addr[OFS_W-1:0];
    assign w_unal  = |w_ofs;
    assign w_widx  = w_addr[ADDR_W-1:OFS_W] + WI_W'(w_beat1);
    assign w_rword = r_mem[w_widx];
    assign bus.rsp_rdata = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RST_ST;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_acc)
                    w_next = w_unal ? S_SPLIT : (bus.req_we ? S_IDLE : S_RESP);
                else if (r_state == S_RESP && bus.rsp_ready)
                    w_next = S_IDLE;
            end
            S_SPLIT: w_next = r_we ? S_IDLE : S_RESP;
`ifdef SRAM_INIT_CLEAR_EN
            S_INIT:  w_next = (&r_init_cnt) ? S_IDLE : S_INIT;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.req_ready = bus.rsp_ready;
            end
            default: ;
        endcase
    end

    // Byte j of the addressed word pairs with lane (j - ofs) mod NB; each beat owns one side of ofs.
    always_comb begin
        logic [OFS_W-1:0] w_lane;
        logic [OFS_W-1:0] w_byt;
        logic             w_sel;
        w_lane     = '0;
        w_byt      = '0;
        w_sel      = 1'b0;
        w_mem_mask = '0;
        w_mem_wdat = '0;
        w_rot      = '0;
        w_lo       = '0;
        for (int j = 0; j < NB; j++) begin
            w_lane = OFS_W'(j) - w_ofs;
            w_sel  = w_beat1 ? (OFS_W'(j) < w_ofs) : (OFS_W'(j) >= w_ofs);
            w_mem_mask[j]       = w_sel && w_be[w_lane];
            w_mem_wdat[8*j +: 8] = w_wdata[8*w_lane +: 8];
            w_byt = OFS_W'(j) + w_ofs;
            w_rot[8*j +: 8] = w_rword[8*w_byt +: 8];
            w_lo[j]         = (w_byt >= w_ofs);
        end
        w_mem_we  = (w_acc || w_beat1) && w_we;
        w_mem_idx = w_widx;
`ifdef SRAM_INIT_CLEAR_EN
        if (r_state == S_INIT) begin
            w_mem_we   = 1'b1;
            w_mem_idx  = r_init_cnt;
            w_mem_mask = '1;
            w_mem_wdat = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int j = 0; j < NB; j++)
                if (w_mem_mask[j]) r_mem[w_mem_idx][8*j +: 8] <= w_mem_wdat[8*j +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_part  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_acc && w_unal) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_be    <= bus.req_be;
                r_wdata <= bus.req_wdata;
            end
            if (w_acc && !bus.req_we) begin
                if (w_unal) r_part  <= w_rot;
                else        r_rdata <= w_rot;
            end
            if (w_beat1 && !r_we) begin
                for (int i = 0; i < NB; i++)
                    r_rdata[8*i +: 8] <= w_lo[i] ? r_part[8*i +: 8] : w_rot[8*i +: 8];
            end
        end
    end

`ifdef SRAM_INIT_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_init_cnt <= '0;
        else if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
    end
`endif
endmodule
